// File: rtl/fifo_mp_if.sv
// Push/pop bundle of the multi-port FIFO. The err field exists only when FIFO_MP_ERR_EN is defined.
interface fifo_mp_if #(
  parameter int WIDTH = 32,
  parameter int HEADS = 2,
  parameter int TAILS = 2,
  parameter int CW    = 5
);
  logic [HEADS-1:0]            push;
  logic [HEADS-1:0][WIDTH-1:0] dinp;
  logic [HEADS-1:0]            src_rdy;
  logic [CW-1:0]               src_num_avail;
  logic                        src_afull;
  logic [TAILS-1:0]            pop;
  logic [TAILS-1:0][WIDTH-1:0] doup;
  logic [TAILS-1:0]            dst_vld;
  logic [CW-1:0]               dst_num_avail;
  logic                        dst_empty;
`ifdef FIFO_MP_ERR_EN
  logic [1:0]                  err;

  modport master (
    output push, dinp, pop,
    input  src_rdy, src_num_avail, src_afull, doup, dst_vld, dst_num_avail, dst_empty, err
  );
  modport slave (
    input  push, dinp, pop,
    output src_rdy, src_num_avail, src_afull, doup, dst_vld, dst_num_avail, dst_empty, err
  );
`else
  modport master (
    output push, dinp, pop,
    input  src_rdy, src_num_avail, src_afull, doup, dst_vld, dst_num_avail, dst_empty
  );
  modport slave (
    input  push, dinp, pop,
    output src_rdy, src_num_avail, src_afull, doup, dst_vld, dst_num_avail, dst_empty
  );
`endif
endinterface

// File: rtl/fifo_mp.sv
// Synchronous multi-port FIFO: HEADS pushes and TAILS pops per cycle, first-word fall-through.
// Optional sticky {underflow, overflow} flags on bus.err when FIFO_MP_ERR_EN is defined.
module fifo_mp #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int HEADS     = 2,
  parameter int TAILS     = 2,
  parameter int AFULL_THR = 2
) (
  input logic      clk,
  input logic      rst,
  fifo_mp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_mp: DEPTH must be a power of 2 and >= 2");
  end
  if (HEADS < 1 || HEADS > DEPTH) begin : g_bad_heads
    $error("fifo_mp: HEADS must be in 1..DEPTH");
  end
  if (TAILS < 1 || TAILS > DEPTH) begin : g_bad_tails
    $error("fifo_mp: TAILS must be in 1..DEPTH");
  end
  if (AFULL_THR < 0 || AFULL_THR > DEPTH) begin : g_bad_thr
    $error("fifo_mp: AFULL_THR must be in 0..DEPTH");
  end

  logic [PW-1:0]    wptr, rptr, count, count_next, free_cnt;
  logic [PW-1:0]    npush, npop;
  logic [HEADS-1:0] rdy, push_acc;
  logic [TAILS-1:0] vld, pop_acc;
  logic [WIDTH-1:0] mem [DEPTH];

  assign free_cnt = PW'(DEPTH) - count;

  // Ready/valid come only from the registered count, never from this cycle's requests.
  always_comb begin
    rdy = '0;
    vld = '0;
    for (int i = 0; i < HEADS; i++) rdy[i] = PW'(i) < free_cnt;
    for (int i = 0; i < TAILS; i++) vld[i] = PW'(i) < count;
  end

  // Accepted requests form an unbroken prefix starting at port 0.
  always_comb begin
    npush    = '0;
    push_acc = '0;
    for (int i = 0; i < HEADS; i++) begin
      if (bus.push[i] && rdy[i] && npush == PW'(i)) begin
        push_acc[i] = 1'b1;
        npush       = npush + 1'b1;
      end
    end
    npop    = '0;
    pop_acc = '0;
    for (int i = 0; i < TAILS; i++) begin
      if (bus.pop[i] && vld[i] && npop == PW'(i)) begin
        pop_acc[i] = 1'b1;
        npop       = npop + 1'b1;
      end
    end
  end

  assign count_next = count + npush - npop;

  // Stage p0: pointer/count registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + npush;
      rptr  <= rptr + npop;
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < HEADS; i++) begin
        if (push_acc[i]) mem[wptr[AW-1:0] + AW'(i)] <= bus.dinp[i];
      end
    end
  end

  always_comb begin
    bus.doup = '0;
    for (int i = 0; i < TAILS; i++) begin
      if (vld[i]) bus.doup[i] = mem[rptr[AW-1:0] + AW'(i)];
    end
  end

  assign bus.src_rdy       = rdy;
  assign bus.dst_vld       = vld;
  assign bus.dst_num_avail = count;
  assign bus.src_num_avail = free_cnt;
  assign bus.dst_empty     = (count == '0);
  assign bus.src_afull     = (free_cnt <= PW'(AFULL_THR));

`ifdef FIFO_MP_ERR_EN
  logic [1:0] err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= '0;
    end else begin
      if (|(bus.push & ~push_acc)) err_q[0] <= 1'b1;
      if (|(bus.pop & ~pop_acc))   err_q[1] <= 1'b1;
    end
  end

  assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_fifo_mp.sv
// Bench for fifo_mp: directed scenarios plus random traffic against a queue-based reference model.
module tb_fifo_mp;
  localparam int WIDTH     = 32;
  localparam int DEPTH     = 16;
  localparam int HEADS     = 2;
  localparam int TAILS     = 2;
  localparam int AFULL_THR = 2;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_mp_if #(.WIDTH(WIDTH), .HEADS(HEADS), .TAILS(TAILS), .CW(CW)) bus ();

  fifo_mp #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .HEADS(HEADS), .TAILS(TAILS), .AFULL_THR(AFULL_THR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [WIDTH-1:0] q[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: whatever the inputs at this edge do to a plain queue of words.
  function automatic void model_step();
    int cnt, np, nq;
    if (!rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      return;
    end
    cnt = q.size();
    np  = 0;
    nq  = 0;
    for (int i = 0; i < HEADS; i++) begin
      if (bus.push[i]) begin
        if (np == i && i < DEPTH - cnt) np++;
        else m_ovf = 1'b1;
      end
    end
    for (int i = 0; i < TAILS; i++) begin
      if (bus.pop[i]) begin
        if (nq == i && i < cnt) nq++;
        else m_udf = 1'b1;
      end
    end
    for (int i = 0; i < nq; i++) void'(q.pop_front());
    for (int i = 0; i < np; i++) q.push_back(bus.dinp[i]);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      int sz;
      sz = q.size();
      chk("dst_num_avail", 32'(bus.dst_num_avail), sz);
      chk("src_num_avail", 32'(bus.src_num_avail), DEPTH - sz);
      chk("dst_empty", 32'(bus.dst_empty), 32'(sz == 0));
      chk("src_afull", 32'(bus.src_afull), 32'(DEPTH - sz <= AFULL_THR));
      for (int i = 0; i < HEADS; i++)
        chk($sformatf("src_rdy[%0d]", i), 32'(bus.src_rdy[i]), 32'(i < DEPTH - sz));
      for (int i = 0; i < TAILS; i++) begin
        chk($sformatf("dst_vld[%0d]", i), 32'(bus.dst_vld[i]), 32'(i < sz));
        chk($sformatf("doup[%0d]", i), bus.doup[i], (i < sz) ? q[i] : 32'h0);
      end
`ifdef FIFO_MP_ERR_EN
      chk("err", 32'(bus.err), {30'h0, m_udf, m_ovf});
`endif
    end
  end

  function automatic logic [HEADS-1:0][WIDTH-1:0] pk(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [HEADS-1:0][WIDTH-1:0] v;
    v    = '0;
    v[0] = a;
    v[1] = b;
    return v;
  endfunction

  task automatic cyc(input logic r, input logic [HEADS-1:0] p,
                     input logic [HEADS-1:0][WIDTH-1:0] d, input logic [TAILS-1:0] pp);
    rst      = r;
    bus.push = p;
    bus.dinp = d;
    bus.pop  = pp;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic [HEADS-1:0][WIDTH-1:0] d;
    logic [HEADS-1:0] p;
    logic [TAILS-1:0] pp;
    logic r;

    // Reset then idle
    cyc(1'b0, '0, '0, '0);
    cyc(1'b0, '0, '0, '0);
    chk_en = 1'b1;
    cyc(1'b1, '0, '0, '0);
    chk("t1_src_num_avail", 32'(bus.src_num_avail), 16);
    chk("t1_dst_num_avail", 32'(bus.dst_num_avail), 0);
    chk("t1_dst_empty", 32'(bus.dst_empty), 1);
    chk("t1_src_rdy", 32'(bus.src_rdy), 32'h3);
    chk("t1_dst_vld", 32'(bus.dst_vld), 0);
    chk("t1_doup0", bus.doup[0], 0);

    // Fill with pairs, then one dropped push
    for (int k = 0; k < 8; k++) cyc(1'b1, 2'b11, pk(32'hA000_0000 + k, 32'hB000_0000 + k), 2'b00);
    chk("t2_src_num_avail", 32'(bus.src_num_avail), 0);
    chk("t2_src_rdy", 32'(bus.src_rdy), 0);
    chk("t2_src_afull", 32'(bus.src_afull), 1);
    chk("t2_doup0", bus.doup[0], 32'hA000_0000);
    chk("t2_doup1", bus.doup[1], 32'hB000_0000);
    cyc(1'b1, 2'b11, pk(32'hDEAD_0000, 32'hBEEF_0000), 2'b00);
    chk("t2_dst_num_avail", 32'(bus.dst_num_avail), 16);
`ifdef FIFO_MP_ERR_EN
    chk("t2_err", 32'(bus.err), 32'h1);
`endif

    // Drain in pairs
    for (int k = 0; k < 8; k++) begin
      chk("t3_doup0", bus.doup[0], 32'hA000_0000 + k);
      chk("t3_doup1", bus.doup[1], 32'hB000_0000 + k);
      cyc(1'b1, 2'b00, '0, 2'b11);
    end
    chk("t3_dst_empty", 32'(bus.dst_empty), 1);
    chk("t3_dst_vld", 32'(bus.dst_vld), 0);

    // count=1 with simultaneous double push and double pop
    cyc(1'b1, 2'b01, pk(32'hC000_0001, 32'h0), 2'b00);
    cyc(1'b1, 2'b11, pk(32'hD000_0000, 32'hD000_0001), 2'b11);
    chk("t4_dst_num_avail", 32'(bus.dst_num_avail), 2);
    chk("t4_doup0", bus.doup[0], 32'hD000_0000);
    chk("t4_doup1", bus.doup[1], 32'hD000_0001);
`ifdef FIFO_MP_ERR_EN
    chk("t4_err", 32'(bus.err) & 32'h2, 32'h2);
`endif

    // Gap at port 0 writes nothing; then steady 2-in/2-out across the wrap
    cyc(1'b1, 2'b10, pk(32'h0, 32'hE000_0000), 2'b00);
    chk("t5_gap_count", 32'(bus.dst_num_avail), 2);
    cyc(1'b1, 2'b11, pk(32'hF000_0000, 32'hF000_0001), 2'b00);
    for (int k = 0; k < 20; k++)
      cyc(1'b1, 2'b11, pk(32'h5000_0000 + 2 * k, 32'h5000_0001 + 2 * k), 2'b11);
    chk("t5_stream_count", 32'(bus.dst_num_avail), 4);
    chk("t5_stream_doup0", bus.doup[0], 32'h5000_0000 + 36);

    // Reset mid-operation at count=9
    cyc(1'b1, 2'b11, pk(32'h6000_0000, 32'h6000_0001), 2'b00);
    cyc(1'b1, 2'b11, pk(32'h6000_0002, 32'h6000_0003), 2'b00);
    cyc(1'b1, 2'b01, pk(32'h6000_0004, 32'h0), 2'b00);
    chk("t6_pre_count", 32'(bus.dst_num_avail), 9);
    cyc(1'b0, 2'b11, pk(32'h7000_0000, 32'h7000_0001), 2'b11);
    chk("t6_count", 32'(bus.dst_num_avail), 0);
    chk("t6_src_num_avail", 32'(bus.src_num_avail), 16);
    chk("t6_doup0", bus.doup[0], 0);
`ifdef FIFO_MP_ERR_EN
    chk("t6_err", 32'(bus.err), 0);
`endif

    // Random traffic with occasional resets
    for (int k = 0; k < 800; k++) begin
      r  = ($urandom_range(0, 99) != 0);
      p  = HEADS'($urandom_range(0, 3));
      pp = TAILS'($urandom_range(0, 3));
      d  = pk($urandom, $urandom);
      cyc(r, p, d, pp);
    end

    cyc(1'b1, '0, '0, '0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
